lstm_gate_sched: RTL and testbench

Round-robin scheduler that time-shares one LSTM gate datapath (the `hiddenSize`-neuron gate array with sigmoid/tanh activation) among `numReq` requesters, typically the input, forget, cell and output gate evaluations of one LSTM time step. It has three jobs:
- grant one requester and register that requester's hidden vector, recurrent weights and biases onto the shared gate operand bus;
- issue a start pulse and wait the gate's fixed latency;
- capture the gate's `final` vector and return it to the granted requester with a done pulse.

---
 rtl/lstm_gate_sched.sv | 161 ++++++++++++++++
 tb/tb_lstm_gate_sched.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lstm_gate_sched.sv
// rtl/lstm_gate_sched.sv - round-robin scheduler sharing one LSTM gate datapath among requesters
//
// Ports:
//   clk_i        clock, all state on rising edge
//   rst_i        asynchronous active-low reset
//   req_i        per-requester request bits
//   reqHid_i     hidden vectors, requester i at slice i
//   reqReW_i     recurrent weights, requester i at slice i
//   reqB_i       biases, requester i at slice i
//   gnt_o        one-hot grant, held from grant edge until capture edge
//   busy_o       high whenever the scheduler is not idle
//   gateHid_o    registered hidden operand to the gate
//   gateReW_o    registered weight operand to the gate
//   gateB_o      registered bias operand to the gate
//   gateStart_o  one-cycle start pulse to the gate
//   gateFinal_i  gate activation result
//   result_o     captured result, held until the next capture
//   done_o       one-hot, one-cycle pulse to the requester whose result is on result_o
module lstm_gate_sched #(
    parameter int dataWidth   = 5,
    parameter int fracWidth   = 2,
    parameter int hiddenSize  = 3,
    parameter int numReq      = 4,
    parameter int gateLatency = 3
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic [numReq-1:0]                            req_i,
    input  logic [dataWidth*hiddenSize*numReq-1:0]       reqHid_i,
    input  logic [dataWidth*hiddenSize*hiddenSize*numReq-1:0] reqReW_i,
    input  logic [dataWidth*hiddenSize*numReq-1:0]       reqB_i,
    output logic [numReq-1:0]                            gnt_o,
    output logic                                         busy_o,
    output logic [dataWidth*hiddenSize-1:0]              gateHid_o,
    output logic [dataWidth*hiddenSize*hiddenSize-1:0]   gateReW_o,
    output logic [dataWidth*hiddenSize-1:0]              gateB_o,
    output logic                                         gateStart_o,
    input  logic [(2*dataWidth+1)*hiddenSize-1:0]        gateFinal_i,
    output logic [(2*dataWidth+1)*hiddenSize-1:0]        result_o,
    output logic [numReq-1:0]                            done_o
);

    localparam int VecW = dataWidth * hiddenSize;
    localparam int MatW = dataWidth * hiddenSize * hiddenSize;
    localparam int ResW = (2 * dataWidth + 1) * hiddenSize;
    localparam int PtrW = (numReq > 1) ? $clog2(numReq) : 1;
    localparam int CntW = $clog2(gateLatency + 1);

    // Elaboration-time parameter sanity checks.
    if (numReq < 2) begin : g_chk_num_req
        $error("lstm_gate_sched: numReq must be at least 2");
    end
    if (gateLatency < 1) begin : g_chk_latency
        $error("lstm_gate_sched: gateLatency must be at least 1");
    end
    if (fracWidth < 0 || fracWidth >= dataWidth) begin : g_chk_frac
        $error("lstm_gate_sched: fracWidth must lie in 0..dataWidth-1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t              state_q;
    logic [PtrW-1:0]     ptr_q;
    logic [CntW-1:0]     cnt_q;
    logic [numReq-1:0]   gnt_q;
    logic [numReq-1:0]   done_q;
    logic [VecW-1:0]     hid_q;
    logic [MatW-1:0]     rew_q;
    logic [VecW-1:0]     bias_q;
    logic [ResW-1:0]     result_q;

    // (base + off) mod numReq, for off in 0..numReq-1 and base < numReq.
    function automatic logic [PtrW-1:0] wrap_idx(input logic [PtrW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= numReq) begin
            s = s - numReq;
        end
        return PtrW'(s);
    endfunction

    // The requester served last is masked during its done cycle so it
    // cannot be re-granted before it has seen its own result.
    logic [numReq-1:0] elig;
    logic              win_vld;
    logic [PtrW-1:0]   win_idx;

    assign elig = req_i & ~done_q;

    // Scan from the largest offset down so the hit closest to ptr_q wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = numReq - 1; k >= 0; k--) begin
            if (elig[wrap_idx(ptr_q, k)]) begin
                win_vld = 1'b1;
                win_idx = wrap_idx(ptr_q, k);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            hid_q    <= '0;
            rew_q    <= '0;
            bias_q   <= '0;
            result_q <= '0;
        end else begin
            done_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (win_vld) begin
                        state_q <= S_ISSUE;
                        gnt_q   <= numReq'(1) << win_idx;
                        hid_q   <= reqHid_i[win_idx*VecW +: VecW];
                        rew_q   <= reqReW_i[win_idx*MatW +: MatW];
                        bias_q  <= reqB_i[win_idx*VecW +: VecW];
                        ptr_q   <= wrap_idx(win_idx, 1);
                        cnt_q   <= '0;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // Capture on the edge closing the gateLatency-th cycle after ISSUE.
                    if (cnt_q == CntW'(gateLatency - 1)) begin
                        result_q <= gateFinal_i;
                        done_q   <= gnt_q;
                        gnt_q    <= '0;
                        state_q  <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign done_o      = done_q;
    assign busy_o      = (state_q != S_IDLE);
    assign gateStart_o = (state_q == S_ISSUE);
    assign gateHid_o   = hid_q;
    assign gateReW_o   = rew_q;
    assign gateB_o     = bias_q;
    assign result_o    = result_q;

endmodule

// File: tb/tb_lstm_gate_sched.sv
// tb/tb_lstm_gate_sched.sv - scoreboard testbench for lstm_gate_sched
module tb_lstm_gate_sched;

    localparam int VW = 15;
    localparam int MW = 45;
    localparam int RW = 33;
    localparam logic [RW-1:0] JUNK = 33'h15A5A5A5A;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0]      req   = '0;
    logic [3:0]      req_b = '0;
    logic [4*VW-1:0] reqHid;
    logic [4*MW-1:0] reqReW;
    logic [4*VW-1:0] reqB;

    logic [3:0]    gnt_a, done_a, gnt_b, done_b;
    logic          busy_a, gs_a, busy_b, gs_b;
    logic [VW-1:0] gh_a, gb_a, gh_b, gb_b;
    logic [MW-1:0] grw_a, grw_b;
    logic [RW-1:0] result_a, result_b;
    logic [RW-1:0] gf_a = JUNK;
    logic [RW-1:0] gf_b = JUNK;

    lstm_gate_sched #(.gateLatency(3)) u_dut (
        .clk_i(clk), .rst_i(rst), .req_i(req),
        .reqHid_i(reqHid), .reqReW_i(reqReW), .reqB_i(reqB),
        .gnt_o(gnt_a), .busy_o(busy_a),
        .gateHid_o(gh_a), .gateReW_o(grw_a), .gateB_o(gb_a),
        .gateStart_o(gs_a), .gateFinal_i(gf_a),
        .result_o(result_a), .done_o(done_a)
    );

    lstm_gate_sched #(.gateLatency(1)) u_dut_l1 (
        .clk_i(clk), .rst_i(rst), .req_i(req_b),
        .reqHid_i(reqHid), .reqReW_i(reqReW), .reqB_i(reqB),
        .gnt_o(gnt_b), .busy_o(busy_b),
        .gateHid_o(gh_b), .gateReW_o(grw_b), .gateB_o(gb_b),
        .gateStart_o(gs_b), .gateFinal_i(gf_b),
        .result_o(result_b), .done_o(done_b)
    );

    logic [VW-1:0] hid_c  [4];
    logic [VW-1:0] bias_c [4];
    logic [MW-1:0] rew_c  [4];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Gate model: the result is valid only during the cycle gateLatency cycles
    // after the start cycle; otherwise junk, so a mistimed capture is visible.
    logic   gate_fixed = 1'b0;
    logic [3:0] hist_a = '0;
    logic [1:0] hist_b = '0;
    always @(negedge clk) begin
        hist_a = {hist_a[2:0], gs_a};
        gf_a   = hist_a[3] ? (gate_fixed ? 33'h0ABCD : {gb_a, gh_a, 3'b101}) : JUNK;
        hist_b = {hist_b[0], gs_b};
        gf_b   = hist_b[1] ? {gb_b, gh_b, 3'b101} : JUNK;
    end

    function automatic logic [RW-1:0] exp_res(input int i);
        return {bias_c[i], hid_c[i], 3'b101};
    endfunction

    typedef struct {
        logic [3:0]    d;
        logic [RW-1:0] r;
        int            c;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];

    task automatic expect_a(input logic [3:0] d, input logic [RW-1:0] r, input int c);
        exp_t e;
        e.d = d; e.r = r; e.c = c;
        sb_a.push_back(e);
    endtask

    task automatic expect_b(input logic [3:0] d, input logic [RW-1:0] r, input int c);
        exp_t e;
        e.d = d; e.r = r; e.c = c;
        sb_b.push_back(e);
    endtask

    // Monitor: every done pulse pops one expectation and is compared against it.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (done_a != 4'b0) begin
                if (sb_a.size() == 0) begin
                    check("unexpected_done_a", {60'b0, done_a}, 64'd0);
                end else begin
                    e = sb_a.pop_front();
                    check("done_a", {60'b0, done_a}, {60'b0, e.d});
                    check("result_a", {31'b0, result_a}, {31'b0, e.r});
                    check("done_cycle_a", 64'(cyc), 64'(e.c));
                end
                check("done_gnt_overlap_a", {60'b0, done_a & gnt_a}, 64'd0);
            end
            if (done_b != 4'b0) begin
                if (sb_b.size() == 0) begin
                    check("unexpected_done_b", {60'b0, done_b}, 64'd0);
                end else begin
                    e = sb_b.pop_front();
                    check("done_b", {60'b0, done_b}, {60'b0, e.d});
                    check("result_b", {31'b0, result_b}, {31'b0, e.r});
                    check("done_cycle_b", 64'(cyc), 64'(e.c));
                end
                check("done_gnt_overlap_b", {60'b0, done_b & gnt_b}, 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_a.size() != 0 || sb_b.size() != 0) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            check("drain_timeout", 64'(sb_a.size() + sb_b.size()), 64'd0);
            sb_a.delete();
            sb_b.delete();
        end
        repeat (3) tick();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic pack_ops();
        reqHid = {hid_c[3], hid_c[2], hid_c[1], hid_c[0]};
        reqB   = {bias_c[3], bias_c[2], bias_c[1], bias_c[0]};
        reqReW = {rew_c[3], rew_c[2], rew_c[1], rew_c[0]};
    endtask

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int cg;
        hid_c[0]  = 15'h1234; hid_c[1]  = 15'h0A0B; hid_c[2]  = 15'h7C01; hid_c[3]  = 15'h2E5F;
        bias_c[0] = 15'h0111; bias_c[1] = 15'h0222; bias_c[2] = 15'h0333; bias_c[3] = 15'h0444;
        rew_c[0]  = 45'h0123456789A; rew_c[1] = 45'h0BCDEF01234;
        rew_c[2]  = 45'h05555555555; rew_c[3] = 45'h0AAAAAAAAAA;
        pack_ops();

        // Reset state, asserted asynchronously before any clock edge.
        #1 rst = 1'b0;
        #1;
        check("reset_ctrl", {54'b0, gnt_a, done_a, busy_a, gs_a}, 64'd0);
        check("reset_result", {31'b0, result_a}, 64'd0);
        check("reset_hid_bias", {34'b0, gh_a, gb_a}, 64'd0);
        check("reset_rew", {19'b0, grw_a}, 64'd0);
        tick();
        rst = 1'b1;

        // Single request with a fixed gate result.
        gate_fixed = 1'b1;
        req = 4'b0001;
        tick();
        cg = cyc;
        req = 4'b0000;
        check("t1_gnt", {60'b0, gnt_a}, 64'h1);
        check("t1_start", {63'b0, gs_a}, 64'h1);
        check("t1_busy", {63'b0, busy_a}, 64'h1);
        check("t1_hid", {49'b0, gh_a}, 64'h1234);
        check("t1_rew", {19'b0, grw_a}, {19'b0, rew_c[0]});
        expect_a(4'b0001, 33'h0ABCD, cg + 4);
        tick();
        check("t1_start_end", {63'b0, gs_a}, 64'h0);
        tick();
        tick();
        check("t1_gnt_held", {60'b0, gnt_a}, 64'h1);
        tick();
        check("t1_gnt_clear", {60'b0, gnt_a}, 64'h0);
        drain();
        gate_fixed = 1'b0;

        // All four requesting continuously from reset.
        req = 4'b1111;
        do_reset();
        cg = cyc + 1;
        for (int k = 0; k < 5; k++) begin
            expect_a(4'b0001 << (k % 4), exp_res(k % 4), cg + 5 * k + 4);
        end
        repeat (21) tick();
        req = 4'b0000;
        drain();

        // Fairness: req0 held, req2 asserted while req0 is being served.
        req = 4'b0001;
        do_reset();
        tick();
        cg = cyc;
        req = 4'b0101;
        expect_a(4'b0001, exp_res(0), cg + 4);
        expect_a(4'b0100, exp_res(2), cg + 9);
        expect_a(4'b0001, exp_res(0), cg + 14);
        expect_a(4'b0010, exp_res(1), cg + 19);
        repeat (5) tick();
        req = 4'b0011;
        repeat (10) tick();
        req = 4'b0000;
        drain();

        // Request withdrawn after one cycle; operands change during WAIT.
        req = 4'b0010;
        tick();
        cg = cyc;
        req = 4'b0000;
        expect_a(4'b0010, exp_res(1), cg + 4);
        tick();
        tick();
        reqHid[VW +: VW] = 15'h7FFF;
        check("t4_gnt", {60'b0, gnt_a}, 64'h2);
        check("t4_hid_frozen", {49'b0, gh_a}, {49'b0, hid_c[1]});
        drain();
        pack_ops();

        // Reset in the middle of WAIT.
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        check("t5_async_ctrl", {54'b0, gnt_a, done_a, busy_a, gs_a}, 64'd0);
        check("t5_async_result", {31'b0, result_a}, 64'd0);
        check("t5_async_hid", {49'b0, gh_a}, 64'd0);
        tick();
        tick();
        req = 4'b1000;
        rst = 1'b1;
        tick();
        cg = cyc;
        req = 4'b0000;
        check("t5_gnt_after", {60'b0, gnt_a}, 64'h8);
        expect_a(4'b1000, exp_res(3), cg + 4);
        drain();

        // gateLatency = 1 instance: grants every 3 cycles.
        req_b = 4'b0011;
        tick();
        cg = cyc;
        check("t6_gnt", {60'b0, gnt_b}, 64'h1);
        expect_b(4'b0001, exp_res(0), cg + 2);
        expect_b(4'b0010, exp_res(1), cg + 5);
        expect_b(4'b0001, exp_res(0), cg + 8);
        repeat (6) tick();
        req_b = 4'b0000;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
